// File: rtl/convolution_pkg.sv
// Shared types and helpers for the convolution output stage.
//   ACC_WIDTH_DEF / OUT_WIDTH_DEF : default accumulator / audio widths
//   GAIN_FULL                     : unity wet gain (fully wet)
//   ramp_state_t                  : wet-ramp FSM states
//   sat16()                       : clamp a wide signed value to 16-bit audio, with flag
package convolution_pkg;

  localparam int         ACC_WIDTH_DEF = 48;
  localparam int         OUT_WIDTH_DEF = 16;
  localparam logic [8:0] GAIN_FULL     = 9'd256;

  typedef enum logic [1:0] {
    MUTED     = 2'd0,
    RAMP_UP   = 2'd1,
    RUNNING   = 2'd2,
    RAMP_DOWN = 2'd3
  } ramp_state_t;

  typedef struct packed {
    logic signed [15:0] val;
    logic               sat;
  } sat16_t;

  function automatic sat16_t sat16(input logic signed [63:0] v);
    sat16_t r;
    r.sat = 1'b1;
    if (v > 64'sd32767)       r.val = 16'sh7FFF;
    else if (v < -64'sd32768) r.val = 16'sh8000;
    else begin
      r.val = v[15:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/round_saturate_shifter.sv
// Registered round-half-up arithmetic shift plus saturation of the wet accumulator.
//   audio_clk, rst_n_in : clock, async active-low reset
//   en                  : load the result register this cycle
//   acc                 : signed accumulator
//   value               : rounded/saturated result (OUT_WIDTH, signed)
//   sat                 : result was clamped
module round_saturate_shifter
  import convolution_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int SHIFT     = 16,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
  input  logic                        audio_clk,
  input  logic                        rst_n_in,
  input  logic                        en,
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic signed [OUT_WIDTH-1:0] value,
  output logic                        sat
);

  // One extra bit so the rounding constant can never overflow the accumulator.
  localparam int W = ACC_WIDTH + 1;
  localparam logic signed [W-1:0] HALF = W'(1) << (SHIFT - 1);
  localparam logic signed [W-1:0] MAXV = W'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic signed [W-1:0] MINV = ~MAXV;

  logic signed [W-1:0]         sum, shifted;
  logic signed [OUT_WIDTH-1:0] val_c;
  logic                        sat_c;

  always_comb begin
    sum     = $signed({acc[ACC_WIDTH-1], acc}) + HALF;
    shifted = sum >>> SHIFT;
    sat_c   = 1'b1;
    if (shifted > MAXV)      val_c = MAXV[OUT_WIDTH-1:0];
    else if (shifted < MINV) val_c = MINV[OUT_WIDTH-1:0];
    else begin
      val_c = shifted[OUT_WIDTH-1:0];
      sat_c = 1'b0;
    end
  end

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      value <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      value <= val_c;
      sat   <= sat_c;
    end
  end

endmodule

// File: rtl/convolution_output_mixer.sv
// Output stage of the convolution engine: rounds/saturates the wet accumulator,
// mixes it with the dry sample of the same frame under a click-free wet ramp.
//   audio_clk, rst_n_in            : clock, async active-low reset
//   audio_trigger, dry_in          : sample strobe and dry sample (latched when idle)
//   convolution_result             : signed wet accumulator
//   produced_convolutional_result  : done flag, rising edge starts the pipeline
//   impulse_in_memory_complete     : enables the wet path (ramp target)
//   wet_gain                       : target wet gain 0..256
//   clear_clip                     : clears clip_sticky
//   audio_out / audio_out_valid    : mixed sample, 1-cycle update pulse
//   clip_sticky, overrun           : saturation flag, dropped-result pulse
//   ramp_level                     : current effective wet gain
// OUT_WIDTH is the 16-bit audio format used by sat16.
module convolution_output_mixer
  import convolution_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int SHIFT     = 16,
  parameter int RAMP_STEP = 8
) (
  input  logic                        audio_clk,
  input  logic                        rst_n_in,
  input  logic                        audio_trigger,
  input  logic signed [OUT_WIDTH-1:0] dry_in,
  input  logic signed [ACC_WIDTH-1:0] convolution_result,
  input  logic                        produced_convolutional_result,
  input  logic                        impulse_in_memory_complete,
  input  logic [8:0]                  wet_gain,
  input  logic                        clear_clip,
  output logic signed [OUT_WIDTH-1:0] audio_out,
  output logic                        audio_out_valid,
  output logic                        clip_sticky,
  output logic                        overrun,
  output logic [8:0]                  ramp_level
);

  localparam int STAGES = 3;
  localparam int PW     = OUT_WIDTH + 10;   // signed sample x signed 10-bit gain

  logic [STAGES:0]              vld_pipe;
  logic                         done_q, done_rise, busy, accept;
  logic signed [ACC_WIDTH-1:0]  acc_r;
  logic signed [OUT_WIDTH-1:0]  dry_hold, dry_s0, wet_s1;
  logic [8:0]                   g_s0, g_min;
  logic                         wet_sat_s1;
  logic signed [9:0]            g10, ng10;
  logic signed [PW-1:0]         p_wet, p_dry;
  logic signed [PW:0]           m_c, m_r, m_sh;
  sat16_t                       s3;
  ramp_state_t                  state, state_nx;
  logic [8:0]                   level_nx, up_lvl, dn_lvl;
  logic [9:0]                   up_sum;

  assign done_rise = produced_convolutional_result & ~done_q;
  assign busy      = |vld_pipe;
  assign accept    = done_rise & ~busy;
  assign g_min     = (wet_gain < ramp_level) ? wet_gain : ramp_level;

  // S0 / control. dry_s0 and g_s0 only load on accept, which cannot happen
  // while busy, so they stay valid through S2 without extra stage copies.
  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      done_q   <= 1'b0;
      vld_pipe <= '0;
      overrun  <= 1'b0;
      dry_hold <= '0;
      acc_r    <= '0;
      dry_s0   <= '0;
      g_s0     <= '0;
    end else begin
      done_q   <= produced_convolutional_result;
      vld_pipe <= {vld_pipe[STAGES-1:0], accept};
      overrun  <= done_rise & busy;
      // S0 samples the old dry_hold when a trigger lands in the same cycle.
      if (audio_trigger && !busy) dry_hold <= dry_in;
      if (accept) begin
        acc_r  <= convolution_result;
        dry_s0 <= dry_hold;
        g_s0   <= g_min;
      end
    end
  end

  // S1
  round_saturate_shifter #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_rss (
    .audio_clk (audio_clk),
    .rst_n_in  (rst_n_in),
    .en        (vld_pipe[0]),
    .acc       (acc_r),
    .value     (wet_s1),
    .sat       (wet_sat_s1)
  );

  // S2 mix; S3 floor shift and clamp
  assign g10   = $signed({1'b0, g_s0});
  assign ng10  = $signed({1'b0, GAIN_FULL}) - g10;
  assign p_wet = PW'(wet_s1) * PW'(g10);
  assign p_dry = PW'(dry_s0) * PW'(ng10);
  assign m_c   = (PW+1)'(p_wet) + (PW+1)'(p_dry);
  assign m_sh  = m_r >>> 8;
  assign s3    = sat16(64'(m_sh));

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      m_r         <= '0;
      audio_out   <= '0;
      clip_sticky <= 1'b0;
    end else begin
      if (vld_pipe[1]) m_r <= m_c;
      if (vld_pipe[2]) audio_out <= s3.val;
      // A saturation wins over a simultaneous clear.
      if ((vld_pipe[1] && wet_sat_s1) || (vld_pipe[2] && s3.sat)) clip_sticky <= 1'b1;
      else if (clear_clip)                                         clip_sticky <= 1'b0;
    end
  end

  assign audio_out_valid = vld_pipe[STAGES];

  // Ramp FSM: advances on the S3 commit edge, well after S0 took the old level.
  // Leaving MUTED applies the first step at once so the next sample already
  // carries some wet signal; likewise the first step down is taken on the
  // sample where complete drops.
  assign up_sum = {1'b0, ramp_level} + 10'(RAMP_STEP);
  assign up_lvl = (up_sum >= {1'b0, GAIN_FULL}) ? GAIN_FULL : up_sum[8:0];
  assign dn_lvl = (ramp_level <= 9'(RAMP_STEP)) ? 9'd0 : ramp_level - 9'(RAMP_STEP);

  always_comb begin
    state_nx = state;
    level_nx = ramp_level;
    if (vld_pipe[2]) begin
      case (state)
        MUTED: begin
          if (impulse_in_memory_complete) begin
            level_nx = up_lvl;
            state_nx = (up_lvl == GAIN_FULL) ? RUNNING : RAMP_UP;
          end else begin
            level_nx = 9'd0;
          end
        end
        RAMP_UP, RUNNING, RAMP_DOWN: begin
          if (impulse_in_memory_complete) begin
            level_nx = up_lvl;
            state_nx = (up_lvl == GAIN_FULL) ? RUNNING : RAMP_UP;
          end else begin
            level_nx = dn_lvl;
            state_nx = (dn_lvl == 9'd0) ? MUTED : RAMP_DOWN;
          end
        end
        default: begin
          level_nx = 9'd0;
          state_nx = MUTED;
        end
      endcase
    end
  end

  always_ff @(posedge audio_clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= MUTED;
      ramp_level <= '0;
    end else begin
      state      <= state_nx;
      ramp_level <= level_nx;
    end
  end

endmodule

// File: tb/tb_convolution_output_mixer.sv
module tb_convolution_output_mixer;

  logic               audio_clk = 1'b0;
  logic               rst_n_in;
  logic               audio_trigger;
  logic signed [15:0] dry_in;
  logic [47:0]        convolution_result;
  logic               produced_convolutional_result;
  logic               impulse_in_memory_complete;
  logic [8:0]         wet_gain;
  logic               clear_clip;
  logic signed [15:0] audio_out;
  logic               audio_out_valid;
  logic               clip_sticky;
  logic               overrun;
  logic [8:0]         ramp_level;

  convolution_output_mixer #(
    .ACC_WIDTH (48), .OUT_WIDTH (16), .SHIFT (16), .RAMP_STEP (64)
  ) dut (
    .audio_clk                     (audio_clk),
    .rst_n_in                      (rst_n_in),
    .audio_trigger                 (audio_trigger),
    .dry_in                        (dry_in),
    .convolution_result            (convolution_result),
    .produced_convolutional_result (produced_convolutional_result),
    .impulse_in_memory_complete    (impulse_in_memory_complete),
    .wet_gain                      (wet_gain),
    .clear_clip                    (clear_clip),
    .audio_out                     (audio_out),
    .audio_out_valid               (audio_out_valid),
    .clip_sticky                   (clip_sticky),
    .overrun                       (overrun),
    .ramp_level                    (ramp_level)
  );

  always #5 audio_clk = ~audio_clk;

  typedef struct { string name; logic [47:0] acc; int dry; int wg; bit c; int exp; } vec_t;
  typedef struct { int v; int cyc; string name; } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0, errors = 0, cyc = 0, valid_cnt = 0, ovr_cnt = 0;

  always @(posedge audio_clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every valid pops one expectation (value + arrival cycle).
  always @(negedge audio_clk) begin
    if (overrun) ovr_cnt++;
    if (audio_out_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got audio_out=%0d with no sample pending (t=%0t)", audio_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_value"}, int'(audio_out), mon_e.v);
        chk({mon_e.name, "_latency"}, cyc, mon_e.cyc);
      end
    end
  end

  function automatic void add(string n, logic [47:0] a, int d, int w, bit c, int e);
    tbl.push_back('{n, a, d, w, c, e});
  endfunction

  // Latch dry, then raise done; output expected 4 cycles after the done drive.
  task automatic send(input vec_t v);
    @(posedge audio_clk); #1;
    dry_in = 16'(v.dry); audio_trigger = 1'b1;
    @(posedge audio_clk); #1;
    audio_trigger = 1'b0; dry_in = ~16'(v.dry);
    convolution_result = v.acc; wet_gain = 9'(v.wg);
    impulse_in_memory_complete = v.c; produced_convolutional_result = 1'b1;
    exp_q.push_back('{v.exp, cyc + 4, v.name});
    @(posedge audio_clk); #1;
    produced_convolutional_result = 1'b0;
    repeat (6) @(posedge audio_clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   vc;
    rst_n_in = 1'b0; audio_trigger = 1'b0; dry_in = '0; convolution_result = '0;
    produced_convolutional_result = 1'b0; impulse_in_memory_complete = 1'b0;
    wet_gain = '0; clear_clip = 1'b0;
    repeat (3) @(posedge audio_clk);
    #1;
    chk("rst_audio_out", int'(audio_out), 0);
    chk("rst_valid", int'(audio_out_valid), 0);
    chk("rst_clip", int'(clip_sticky), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ramp", int'(ramp_level), 0);
    rst_n_in = 1'b1;

    // muted passthrough
    add("muted_1000",  48'h0000_3039_0000,   1000, 256, 0,   1000);
    add("muted_min",   48'h0000_3039_0000, -32768, 256, 0, -32768);
    add("muted_max",   48'h0,               32767,   0, 0,  32767);
    // ramp up / down, step 64, dry 0, wet 1000
    add("up0",   48'h0000_03E8_0000, 0, 256, 1,    0);
    add("up1",   48'h0000_03E8_0000, 0, 256, 1,  250);
    add("up2",   48'h0000_03E8_0000, 0, 256, 1,  500);
    add("up3",   48'h0000_03E8_0000, 0, 256, 1,  750);
    add("run0",  48'h0000_03E8_0000, 0, 256, 1, 1000);
    add("run1",  48'h0000_03E8_0000, 0, 256, 0, 1000);
    add("dn1",   48'h0000_03E8_0000, 0, 256, 0,  750);
    add("dn2",   48'h0000_03E8_0000, 0, 256, 0,  500);
    add("dn3",   48'h0000_03E8_0000, 0, 256, 0,  250);
    add("muted", 48'h0000_03E8_0000, 0, 256, 0,    0);
    // ramp up again with dry 100 mixed in
    add("mix_up0", 48'h0000_03E8_0000, 100, 256, 1,  100);
    add("mix_up1", 48'h0000_03E8_0000, 100, 256, 1,  325);
    add("mix_up2", 48'h0000_03E8_0000, 100, 256, 1,  550);
    add("mix_up3", 48'h0000_03E8_0000, 100, 256, 1,  775);
    add("mix_run", 48'h0000_03E8_0000, 100, 256, 1, 1000);
    // RUNNING: saturation, rounding, mixing, floor
    add("sat_pos",  48'h7FFF_FFFF_FFFF,     0, 256, 1,  32767);
    add("sat_neg",  48'hFF00_0000_0000,     0, 256, 1, -32768);
    add("mix_half", 48'h0000_03E8_8000, -2000, 128, 1,   -500);
    add("wg_zero",  48'h0000_1000_0000,  1234,   0, 1,   1234);
    add("rnd_lo",   48'h0000_0000_7FFF,     0, 256, 1,      0);
    add("rnd_hi",   48'h0000_0000_8000,     0, 256, 1,      1);
    add("rnd_nhalf",48'hFFFF_FFFF_8000,     0, 256, 1,      0);
    add("rnd_nlo",  48'hFFFF_FFFF_7FFF,     0, 256, 1,     -1);
    add("floor",    48'h0,                 -1,   1, 1,     -1);
    add("mix_q",    48'h0000_07D0_0000,   400,  64, 1,    800);

    foreach (tbl[i]) send(tbl[i]);
    #1;
    chk("running_level", int'(ramp_level), 256);
    chk("clip_after_sat", int'(clip_sticky), 1);

    // clear_clip alone
    @(posedge audio_clk); #1 clear_clip = 1'b1;
    @(posedge audio_clk); #1 clear_clip = 1'b0;
    chk("clip_cleared", int'(clip_sticky), 0);

    // clear_clip coincident with an S1 saturation: saturation wins
    @(posedge audio_clk); #1;
    dry_in = 16'sd0; audio_trigger = 1'b1;
    @(posedge audio_clk); #1;
    audio_trigger = 1'b0; convolution_result = 48'h7FFF_FFFF_FFFF; wet_gain = 9'd256;
    produced_convolutional_result = 1'b1;
    exp_q.push_back('{32767, cyc + 4, "clip_race"});
    @(posedge audio_clk); #1 produced_convolutional_result = 1'b0;
    @(posedge audio_clk); #1 clear_clip = 1'b1;
    @(posedge audio_clk); #1 clear_clip = 1'b0;
    repeat (4) @(posedge audio_clk);
    #1 chk("clip_set_beats_clear", int'(clip_sticky), 1);

    // overrun: second done edge two cycles after the first is dropped
    ovr_cnt = 0; vc = valid_cnt;
    @(posedge audio_clk); #1;
    dry_in = 16'sd0; audio_trigger = 1'b1;
    @(posedge audio_clk); #1;
    audio_trigger = 1'b0; convolution_result = 48'h0000_0064_0000; wet_gain = 9'd256;
    produced_convolutional_result = 1'b1;
    exp_q.push_back('{100, cyc + 4, "ovr_first"});
    @(posedge audio_clk); #1;
    produced_convolutional_result = 1'b0; convolution_result = 48'h0000_00C8_0000;
    @(posedge audio_clk); #1 produced_convolutional_result = 1'b1;
    @(posedge audio_clk); #1 produced_convolutional_result = 1'b0;
    repeat (8) @(posedge audio_clk);
    #1;
    chk("overrun_pulses", ovr_cnt, 1);
    chk("overrun_valids", valid_cnt - vc, 1);

    // reset two cycles into the pipeline: nothing comes out
    vc = valid_cnt;
    @(posedge audio_clk); #1;
    dry_in = 16'sd500; audio_trigger = 1'b1;
    @(posedge audio_clk); #1;
    audio_trigger = 1'b0; convolution_result = 48'h0000_03E8_0000;
    produced_convolutional_result = 1'b1;
    @(posedge audio_clk); #1 produced_convolutional_result = 1'b0;
    @(posedge audio_clk); #1 rst_n_in = 1'b0;
    #2;
    chk("midrst_audio_out", int'(audio_out), 0);
    chk("midrst_ramp", int'(ramp_level), 0);
    chk("midrst_clip", int'(clip_sticky), 0);
    @(posedge audio_clk); #1 rst_n_in = 1'b1;
    repeat (8) @(posedge audio_clk);
    #1 chk("midrst_no_valid", valid_cnt - vc, 0);

    // after reset the ramp starts from MUTED: pure dry, then first step
    v = '{"post_rst_muted", 48'h0000_03E8_0000, 100, 256, 1, 100};
    send(v);
    #1 chk("post_rst_level", int'(ramp_level), 64);

    repeat (4) @(posedge audio_clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
